// File: rtl/encrypt_iterative_pkg.sv
// encrypt_iterative_pkg: AES forward-cipher primitives (S-box, GF(2^8) helpers, ShiftRows, MixColumns)
// Contents: rk_w round-key/state width, fsm_t controller states, byte/word/state transform functions.
package encrypt_iterative_pkg;

    localparam int rk_w = 128;

    typedef enum logic {IDLE, RUN} fsm_t;

    // Byte 0x00 maps to the top byte so the table reads in natural S-box order.
    localparam logic [2047:0] sbox_tbl = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return sbox_tbl[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input int n);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 1; k < n; k++) r = xtime(r);
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[k * 8 +: 8] = sbox(s[k * 8 +: 8]);
        return r;
    endfunction

    // Byte (row, col) sits at index row + 4*col, counted from the MSB end.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++)
                r[127 - 8 * (k + 4 * c) -: 8] = s[127 - 8 * (k + 4 * ((c + k) % 4)) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127 - 32 * c -: 32];
            r[127 - 32 * c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                     xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return r;
    endfunction

endpackage

// File: rtl/encrypt_iterative_if.sv
// encrypt_iterative_if: request/result bundle of the iterative AES encryptor
// master drives key, start, state_in; slave returns busy, done, out1.
interface encrypt_iterative_if #(
    parameter int nk = 4
);
    logic [nk*32-1:0] key;
    logic             start;
    logic [127:0]     state_in;
    logic             busy;
    logic             done;
    logic [127:0]     out1;

    modport master (output key, start, state_in, input busy, done, out1);
    modport slave  (input key, start, state_in, output busy, done, out1);
endinterface

// File: rtl/encrypt_iterative_round_forward.sv
// encrypt_iterative_round_forward: one AES encryption round
// state, round_key in; last skips MixColumns for the final round; result out.
module encrypt_iterative_round_forward
    import encrypt_iterative_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] result
);
    logic [127:0] sr;

    assign sr     = shift_rows(sub_bytes(state));
    assign result = (last ? sr : mix_columns(sr)) ^ round_key;
endmodule

// File: rtl/keyExpansion.sv
// keyExpansion: combinational AES key schedule
// key: nk*32-bit cipher key; w: all nr+1 round keys, round key i at w[i*128 +: 128].
module keyExpansion
    import encrypt_iterative_pkg::*;
#(
    parameter int nk = 4,
    parameter int nr = 10
) (
    input  logic [nk*32-1:0]       key,
    output logic [0:(nr+1)*rk_w-1] w
);
    for (genvar i = 0; i < 4 * (nr + 1); i++) begin : g_w
        logic [31:0] wd;
        if (i < nk) begin : g_key
            assign wd = key[(nk - i) * 32 - 1 -: 32];
        end else if (i % nk == 0) begin : g_rot
            assign wd = g_w[i - nk].wd ^ {rcon(i / nk), 24'h0}
                      ^ sub_word({g_w[i - 1].wd[23:0], g_w[i - 1].wd[31:24]});
        end else if (nk > 6 && i % nk == 4) begin : g_sub
            assign wd = g_w[i - nk].wd ^ sub_word(g_w[i - 1].wd);
        end else begin : g_xor
            assign wd = g_w[i - nk].wd ^ g_w[i - 1].wd;
        end
        assign w[i * 32 +: 32] = wd;
    end
endmodule

// File: rtl/encrypt_iterative.sv
// encrypt_iterative: iterative AES-128/192/256 encryptor, one round per clock
// clk, rst_n (sync, active-low); bus: key/start/state_in in, busy/done/out1 out.
module encrypt_iterative
    import encrypt_iterative_pkg::*;
#(
    parameter int nk = 4,
    parameter int nr = 10
) (
    input logic                 clk,
    input logic                 rst_n,
    encrypt_iterative_if.slave  bus
);
    fsm_t                  fsm;
    logic [3:0]            rnd;
    logic [127:0]          st_q;
    logic [127:0]          rk;
    logic [127:0]          nxt;
    logic                  last_rnd;
    logic [nk*32-1:0]      key_q;
    logic [0:(nr+1)*rk_w-1] w;

    // Schedule runs from the latched key so the live key may change mid-block.
    keyExpansion #(.nk(nk), .nr(nr)) u_kexp (.key(key_q), .w(w));

    assign rk       = w[{rnd, 7'd0} +: rk_w];
    assign last_rnd = rnd == 4'(nr);

    encrypt_iterative_round_forward u_round (
        .state    (st_q),
        .round_key(rk),
        .last     (last_rnd),
        .result   (nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm      <= IDLE;
            rnd      <= '0;
            st_q     <= '0;
            key_q    <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.out1 <= '0;
        end else begin
            bus.done <= 1'b0;
            if (fsm == IDLE) begin
                if (bus.start) begin
                    // Round key 0 is the first four key words, taken straight from the live key.
                    key_q    <= bus.key;
                    st_q     <= bus.state_in ^ bus.key[nk*32-1 -: rk_w];
                    rnd      <= 4'd1;
                    bus.busy <= 1'b1;
                    fsm      <= RUN;
                end
            end else if (last_rnd) begin
                bus.out1 <= nxt;
                bus.done <= 1'b1;
                bus.busy <= 1'b0;
                fsm      <= IDLE;
            end else begin
                st_q <= nxt;
                rnd  <= rnd + 4'd1;
            end
        end
    end
endmodule
